reg8_write_arbiter: RTL and testbench
=====================================

# reg8_write_arbiter

Controller that shares one external 8-bit edge-triggered register with asynchronous clear (74273-class part) among NREQ requesters. It arbitrates write requests and sequences the part's D, CP and N_MR pins with a glitch-free setup/strobe/hold pattern. It also services a clear request and keeps a shadow copy of the register contents. It sits between the bus requesters and the register chip on the board-level datapath.

## Interface
- NREQ, 4: number of requesters, 2..8.
- CP  in  1: system clock, all logic on rising edge.
- N_MR  in  1: synchronous active-low reset.
- REQ  in  NREQ: write request per requester, level, held until its ACK.
- WDATA  in  8*NREQ: write data, requester i on bits [8i+7:8i].
- CLR  in  1: clear request, level, held until CLR_ACK.
- ACK  out  NREQ: one-hot, one-cycle pulse when requester's write has completed.
- CLR_ACK  out  1: one-cycle pulse when clear has completed.
- BUSY  out  1: high in any state other than IDLE.
- REG_D  out  8: drives the register chip's D pins.
- REG_CP  out  1: drives the register chip's CP pin.
- REG_N_MR  out  1: drives the register chip's N_MR pin (active-low clear).
- SHADOW  out  8: value the register chip currently holds.

## Operation
- All outputs come directly from flops. REG_CP and REG_N_MR never glitch.
- States: IDLE, SETUP, STROBE, HOLD, CLEAR.
- Arbitration happens on edges where the state is IDLE or HOLD:
  - If CLR is high, go to CLEAR. Clear always beats writes.
  - Else if any REQ bit is high, pick winner w, latch WDATA[w] into REG_D, record w, go to SETUP.
  - Else go to IDLE.
- SETUP: REG_CP=0, REG_D stable. Next state is STROBE.
- STROBE: REG_CP=1; the chip latches REG_D on this rise. Next state is HOLD.
- HOLD:
  - REG_CP=0, REG_D still held.
  - ACK[w]=1 and SHADOW=REG_D.
  - Arbitrate as above; back-to-back writes skip IDLE.
- CLEAR:
  - REG_N_MR=0 for exactly one cycle.
  - CLR_ACK=1 in the same cycle; SHADOW=0.
  - Next state is IDLE. Writes are never arbitrated from CLEAR.
- Round-robin winner: first asserted REQ searching upward from last_winner+1, wrapping modulo NREQ. last_winner updates only when a write is granted.
- WDATA is sampled only at the grant edge. Later changes to WDATA are ignored.
- If REQ[w] drops after grant, the write still completes and ACK[w] still pulses.
- CLR arriving during SETUP or STROBE waits; it is taken at the HOLD arbitration.
- Reset (N_MR low at an edge):
  - Writes state=IDLE, REG_CP=0, REG_D=0, REG_N_MR=0 (clears the chip), SHADOW=0, ACK=0, CLR_ACK=0, BUSY=0, last_winner=NREQ-1 (requester 0 wins first).
  - The first edge with N_MR high returns REG_N_MR to 1.
- Reset mid-write aborts the write; no ACK is produced.

## Timing
- Write latency: REQ sampled high at edge e0 (IDLE) gives:
  - REG_D valid after e0.
  - REG_CP high after e1.
  - REG_CP low plus ACK and SHADOW update after e2.
  - ACK visible during cycle e2..e3.
- Setup of REG_D to the REG_CP rise: 1 full cycle. Hold after the fall: 1 full cycle (HOLD).
- Throughput: one write per 3 cycles when requests are continuous.
- Clear latency: CLR sampled at an IDLE/HOLD edge gives REG_N_MR=0 and CLR_ACK for the following cycle.
- BUSY is registered and true in SETUP, STROBE, HOLD and CLEAR.

## Configuration
- REG8_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins. last_winner is unused, and a continuously asserted REQ[0] starves the others.
  - Undefined (default): round-robin as specified.

## Structure
- Package reg8_arb_pkg:
  - State enum typedef (IDLE, SETUP, STROBE, HOLD, CLEAR).
  - Localparam MAX_NREQ=8.
  - Width helper for the winner index.
- Sub-module round_robin_pick: combinational; inputs REQ and last_winner, outputs a one-hot grant and an index. The fixed-priority path is selected inside it by the macro.
- FORMAL block assertions:
  - ACK is one-hot0.
  - REG_CP is high only in STROBE.
  - REG_D is stable from SETUP through HOLD.
  - SHADOW equals the chip model's Q after HOLD and CLEAR.

## Test plan
- Reset, then REQ=0001, WDATA[0]=0xA5 → REG_CP rises 2 edges after grant, ACK=0001 on the third cycle, SHADOW=0xA5.
- REQ=1111 held with distinct data 0x11/0x22/0x33/0x44 → grants in order 0,1,2,3,0 at a 3-cycle spacing. With REG8_ARB_FIXED_PRIO_EN, only requester 0 is granted.
- CLR and REQ[2] raised in the same IDLE cycle → CLEAR first (REG_N_MR=0 for 1 cycle, SHADOW=0), then the write of requester 2.
- CLR raised during STROBE of a 0x5A write → write completes (ACK, SHADOW=0x5A), then CLEAR → SHADOW=0.
- WDATA changed and REQ dropped one cycle after grant → REG_D keeps the granted value, ACK still pulses.
- N_MR low during STROBE → next cycle IDLE, REG_CP=0, REG_N_MR=0, no ACK. After release, REQ[1] wins only if REQ[0] is low.

Source files
------------

// File: rtl/reg8_arb_pkg.sv
// Shared types for the 74273-class register write arbiter.
// FSM states, requester limit and index width helper.
package reg8_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    CLEAR
  } state_t;

  localparam int MAX_NREQ = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg8_write_arbiter_pick.sv
// Winner selection: round-robin from last_winner+1, or fixed
// priority (lowest index) when REG8_ARB_FIXED_PRIO_EN is defined.
module round_robin_pick
  import reg8_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

`ifdef REG8_ARB_FIXED_PRIO_EN
  logic unused_lw;
  assign unused_lw = ^last_winner;

  always_comb begin
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i]) idx = IW'(i);
  end
`else
  int d;
  int best;

  // Distance upward from last_winner+1; smallest wins.
  always_comb begin
    idx  = '0;
    d    = 0;
    best = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - 1 - int'(last_winner)) % NREQ;
      if (req[i] && d < best) begin
        best = d;
        idx  = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (|req)
      grant = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: rtl/reg8_write_arbiter.sv
// Shares one 74273-class register among NREQ writers plus clear.
// Build option: REG8_ARB_FIXED_PRIO_EN selects fixed priority.
module reg8_write_arbiter
  import reg8_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic              CP,
  input  logic              N_MR,
  input  logic [NREQ-1:0]   REQ,
  input  logic [8*NREQ-1:0] WDATA,
  input  logic              CLR,
  output logic [NREQ-1:0]   ACK,
  output logic              CLR_ACK,
  output logic              BUSY,
  output logic [7:0]        REG_D,
  output logic              REG_CP,
  output logic              REG_N_MR,
  output logic [7:0]        SHADOW
);

  localparam int IW = idx_w(NREQ);

  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("NREQ out of range");
  end

  state_t          state;
  state_t          state_n;
  logic            grant_en;
  logic [IW-1:0]   last_winner;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_grant;
  logic [NREQ-1:0] win_oh;
  logic [7:0]      grant_data;

  round_robin_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req        (REQ),
    .last_winner(last_winner),
    .grant      (pick_grant),
    .idx        (pick_idx)
  );

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_grant[i]) grant_data = WDATA[i*8 +: 8];
  end

  always_comb begin
    state_n  = state;
    grant_en = 1'b0;
    unique case (state)
      IDLE, HOLD: begin
        if (CLR) begin
          state_n = CLEAR;
        end else if (|REQ) begin
          state_n  = SETUP;
          grant_en = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      SETUP:   state_n = STROBE;
      STROBE:  state_n = HOLD;
      CLEAR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CP) begin
    if (!N_MR) state <= IDLE;
    else       state <= state_n;
  end

  // Pin outputs are decoded from the next state so each is a flop.
  always_ff @(posedge CP) begin
    if (!N_MR) begin
      REG_D       <= '0;
      REG_CP      <= 1'b0;
      REG_N_MR    <= 1'b0;
      SHADOW      <= '0;
      ACK         <= '0;
      CLR_ACK     <= 1'b0;
      BUSY        <= 1'b0;
      win_oh      <= '0;
      last_winner <= IW'(NREQ - 1);
    end else begin
      REG_CP   <= (state_n == STROBE);
      REG_N_MR <= (state_n != CLEAR);
      CLR_ACK  <= (state_n == CLEAR);
      BUSY     <= (state_n != IDLE);
      ACK      <= (state_n == HOLD) ? win_oh : '0;
      if (state_n == HOLD)
        SHADOW <= REG_D;
      else if (state_n == CLEAR)
        SHADOW <= '0;
      if (grant_en) begin
        REG_D       <= grant_data;
        win_oh      <= pick_grant;
        last_winner <= pick_idx;
      end
    end
  end

`ifdef FORMAL
  logic [7:0] chip_q;

  always_ff @(posedge CP) begin
    if (!REG_N_MR)   chip_q <= '0;
    else if (REG_CP) chip_q <= REG_D;
  end

  a_ack_oh: assert property (@(posedge CP) $onehot0(ACK));
  a_cp: assert property (@(posedge CP)
    REG_CP |-> state == STROBE);
  a_d: assert property (@(posedge CP) disable iff (!N_MR)
    (state inside {STROBE, HOLD}) |-> $stable(REG_D));
  a_sh_hold: assert property (@(posedge CP) disable iff (!N_MR)
    state == HOLD |-> SHADOW == chip_q);
  a_sh_clr: assert property (@(posedge CP) disable iff (!N_MR)
    state == CLEAR |-> SHADOW == 8'h00);
`endif

endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Bench for reg8_write_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level arbitration model.
module tb_reg8_write_arbiter;

  localparam int NREQ = 4;

  logic              CP    = 1'b0;
  logic              N_MR  = 1'b0;
  logic [NREQ-1:0]   REQ   = '0;
  logic [8*NREQ-1:0] WDATA = '0;
  logic              CLR   = 1'b0;
  logic [NREQ-1:0]   ACK;
  logic              CLR_ACK;
  logic              BUSY;
  logic [7:0]        REG_D;
  logic              REG_CP;
  logic              REG_N_MR;
  logic [7:0]        SHADOW;

  int errors = 0;
  int checks = 0;
  int last_w = NREQ - 1;
  int cyc    = 0;

  reg8_write_arbiter #(.NREQ(NREQ)) dut (
    .CP      (CP),
    .N_MR    (N_MR),
    .REQ     (REQ),
    .WDATA   (WDATA),
    .CLR     (CLR),
    .ACK     (ACK),
    .CLR_ACK (CLR_ACK),
    .BUSY    (BUSY),
    .REG_D   (REG_D),
    .REG_CP  (REG_CP),
    .REG_N_MR(REG_N_MR),
    .SHADOW  (SHADOW)
  );

  always #5 CP = ~CP;

  task automatic tick;
    @(posedge CP);
    #1;
    cyc++;
  endtask

  // Winner rule: first set bit upward from last+1 (or lowest index).
  function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef REG8_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++)
      if (r[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic test_reset;
    N_MR = 1'b0;
    REQ  = '0;
    CLR  = 1'b0;
    tick;
    tick;
    checks++;
    if ({REG_CP, REG_N_MR, BUSY, CLR_ACK, ACK, REG_D, SHADOW} !== '0) begin
      errors++;
      $display("FAIL reset_outs: cp=%b nmr=%b busy=%b cack=%b ack=%b d=%h sh=%h, want all 0",
               REG_CP, REG_N_MR, BUSY, CLR_ACK, ACK, REG_D, SHADOW);
    end
    N_MR = 1'b1;
    tick;
    checks++;
    if (REG_N_MR !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: nmr=%b busy=%b, want 1 0", REG_N_MR, BUSY);
    end
    last_w = NREQ - 1;
  endtask

  task automatic test_single;
    WDATA[7:0] = 8'hA5;
    REQ = 4'b0001;
    tick;
    checks++;
    if (REG_D !== 8'hA5 || REG_CP !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_setup: d=%h cp=%b busy=%b, want a5 0 1", REG_D, REG_CP, BUSY);
    end
    tick;
    checks++;
    if (REG_CP !== 1'b1 || ACK !== 4'b0000) begin
      errors++;
      $display("FAIL single_strobe: cp=%b ack=%b, want 1 0000", REG_CP, ACK);
    end
    tick;
    checks++;
    if (REG_CP !== 1'b0 || ACK !== 4'b0001 || SHADOW !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: cp=%b ack=%b sh=%h, want 0 0001 a5", REG_CP, ACK, SHADOW);
    end
    REQ = '0;
    tick;
    checks++;
    if (ACK !== 4'b0000 || BUSY !== 1'b0 || SHADOW !== 8'hA5) begin
      errors++;
      $display("FAIL single_idle: ack=%b busy=%b sh=%h, want 0000 0 a5", ACK, BUSY, SHADOW);
    end
    last_w = 0;
  endtask

  task automatic test_round_robin;
    int n;
    int w;
    int ack_cyc [5];
    logic [NREQ-1:0] exp;
    test_reset;
    for (int i = 0; i < NREQ; i++)
      WDATA[i*8 +: 8] = 8'((i + 1) * 17);
    REQ = '1;
    n = 0;
    for (int t = 0; t < 25 && n < 5; t++) begin
      tick;
      if (ACK !== '0) begin
        w = pick('1, last_w);
        exp = '0;
        exp[w] = 1'b1;
        checks++;
        if (ACK !== exp) begin
          errors++;
          $display("FAIL rr_order[%0d]: ack=%b, want %b", n, ACK, exp);
        end
        checks++;
        if (SHADOW !== 8'((w + 1) * 17)) begin
          errors++;
          $display("FAIL rr_data[%0d]: sh=%h, want %h", n, SHADOW, 8'((w + 1) * 17));
        end
        ack_cyc[n] = cyc;
        if (n > 0) begin
          checks++;
          if (cyc - ack_cyc[n-1] != 3) begin
            errors++;
            $display("FAIL rr_spacing[%0d]: %0d cycles, want 3", n, cyc - ack_cyc[n-1]);
          end
        end
        last_w = w;
        n++;
        if (n == 5) REQ = '0;
      end
    end
    REQ = '0;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_count: %0d acks, want 5", n);
    end
    tick;
    tick;
  endtask

  task automatic test_clr_first;
    WDATA[23:16] = 8'h6E;
    REQ = 4'b0100;
    CLR = 1'b1;
    tick;
    checks++;
    if (REG_N_MR !== 1'b0 || CLR_ACK !== 1'b1 || SHADOW !== 8'h00 || REG_CP !== 1'b0) begin
      errors++;
      $display("FAIL clr_first: nmr=%b cack=%b sh=%h cp=%b, want 0 1 00 0",
               REG_N_MR, CLR_ACK, SHADOW, REG_CP);
    end
    CLR = 1'b0;
    tick;
    checks++;
    if (REG_N_MR !== 1'b1 || CLR_ACK !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL clr_done: nmr=%b cack=%b busy=%b, want 1 0 0", REG_N_MR, CLR_ACK, BUSY);
    end
    tick;
    tick;
    tick;
    checks++;
    if (ACK !== 4'b0100 || SHADOW !== 8'h6E) begin
      errors++;
      $display("FAIL clr_then_write: ack=%b sh=%h, want 0100 6e", ACK, SHADOW);
    end
    REQ = '0;
    tick;
    last_w = 2;
  endtask

  task automatic test_clr_in_strobe;
    WDATA[7:0] = 8'h5A;
    REQ = 4'b0001;
    tick;
    tick;
    checks++;
    if (REG_CP !== 1'b1) begin
      errors++;
      $display("FAIL cs_strobe: cp=%b, want 1", REG_CP);
    end
    CLR = 1'b1;
    tick;
    checks++;
    if (ACK !== 4'b0001 || SHADOW !== 8'h5A || REG_N_MR !== 1'b1) begin
      errors++;
      $display("FAIL cs_write_done: ack=%b sh=%h nmr=%b, want 0001 5a 1", ACK, SHADOW, REG_N_MR);
    end
    REQ = '0;
    tick;
    checks++;
    if (REG_N_MR !== 1'b0 || CLR_ACK !== 1'b1 || SHADOW !== 8'h00 || ACK !== '0) begin
      errors++;
      $display("FAIL cs_clear: nmr=%b cack=%b sh=%h ack=%b, want 0 1 00 0000",
               REG_N_MR, CLR_ACK, SHADOW, ACK);
    end
    CLR = 1'b0;
    tick;
    last_w = 0;
  endtask

  task automatic test_wdata_change;
    WDATA[15:8] = 8'hC3;
    REQ = 4'b0010;
    tick;
    WDATA[15:8] = 8'h3C;
    REQ = '0;
    tick;
    checks++;
    if (REG_D !== 8'hC3 || REG_CP !== 1'b1) begin
      errors++;
      $display("FAIL wd_hold: d=%h cp=%b, want c3 1", REG_D, REG_CP);
    end
    tick;
    checks++;
    if (ACK !== 4'b0010 || SHADOW !== 8'hC3 || REG_D !== 8'hC3) begin
      errors++;
      $display("FAIL wd_ack: ack=%b sh=%h d=%h, want 0010 c3 c3", ACK, SHADOW, REG_D);
    end
    tick;
    last_w = 1;
  endtask

  task automatic test_reset_mid_write;
    WDATA[7:0] = 8'h77;
    REQ = 4'b0001;
    tick;
    tick;
    N_MR = 1'b0;
    tick;
    checks++;
    if (BUSY !== 1'b0 || REG_CP !== 1'b0 || REG_N_MR !== 1'b0 || ACK !== '0 || SHADOW !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: busy=%b cp=%b nmr=%b ack=%b sh=%h, want 0 0 0 0000 00",
               BUSY, REG_CP, REG_N_MR, ACK, SHADOW);
    end
    last_w = NREQ - 1;
    WDATA[7:0]  = 8'h10;
    WDATA[15:8] = 8'h21;
    REQ  = 4'b0011;
    N_MR = 1'b1;
    tick;
    checks++;
    if (REG_N_MR !== 1'b1 || REG_D !== 8'h10) begin
      errors++;
      $display("FAIL rst_first_grant: nmr=%b d=%h, want 1 10", REG_N_MR, REG_D);
    end
    tick;
    tick;
    checks++;
    if (ACK !== 4'b0001) begin
      errors++;
      $display("FAIL rst_ack0: ack=%b, want 0001", ACK);
    end
    REQ = 4'b0010;
    tick;
    checks++;
    if (REG_D !== 8'h21 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL rst_grant1: d=%h busy=%b, want 21 1", REG_D, BUSY);
    end
    tick;
    tick;
    checks++;
    if (ACK !== 4'b0010 || SHADOW !== 8'h21) begin
      errors++;
      $display("FAIL rst_ack1: ack=%b sh=%h, want 0010 21", ACK, SHADOW);
    end
    REQ = '0;
    tick;
    last_w = 1;
  endtask

  task automatic test_random;
    logic [NREQ-1:0] r0, r1, r2, req_now, exp;
    logic            c0, clr_now, cp_prev;
    logic [7:0]      chip_q;
    logic [7:0]      data [NREQ];
    int              w;
    test_reset;
    r0 = '0; r1 = '0; r2 = '0;
    c0 = 1'b0;
    cp_prev = 1'b0;
    chip_q  = 8'h00;
    for (int i = 0; i < NREQ; i++) data[i] = 8'h00;
    for (int t = 0; t < 400; t++) begin
      req_now = REQ;
      clr_now = CLR;
      tick;
      r2 = r1;
      r1 = r0;
      r0 = req_now;
      c0 = clr_now;
      if (!REG_N_MR) chip_q = 8'h00;
      else if (REG_CP && !cp_prev) chip_q = REG_D;
      cp_prev = REG_CP;
      checks++;
      if (!$onehot0(ACK)) begin
        errors++;
        $display("FAIL rnd_onehot: ack=%b at cyc %0d", ACK, cyc);
      end
      if (ACK !== '0) begin
        w = pick(r2, last_w);
        exp = '0;
        if (w >= 0) exp[w] = 1'b1;
        checks++;
        if (ACK !== exp) begin
          errors++;
          $display("FAIL rnd_winner: ack=%b, want %b at cyc %0d", ACK, exp, cyc);
        end
        if (w >= 0) begin
          checks++;
          if (SHADOW !== data[w] || SHADOW !== chip_q) begin
            errors++;
            $display("FAIL rnd_shadow: sh=%h, want %h (chip %h) at cyc %0d",
                     SHADOW, data[w], chip_q, cyc);
          end
          last_w = w;
        end
        REQ = REQ & ~ACK;
      end
      if (CLR_ACK) begin
        checks++;
        if (SHADOW !== 8'h00 || REG_N_MR !== 1'b0 || c0 !== 1'b1) begin
          errors++;
          $display("FAIL rnd_clear: sh=%h nmr=%b clr_seen=%b, want 00 0 1 at cyc %0d",
                   SHADOW, REG_N_MR, c0, cyc);
        end
        CLR = 1'b0;
      end
      if (t < 340) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!REQ[i] && !ACK[i] && $urandom_range(3) == 0) begin
            data[i] = 8'($urandom);
            WDATA[i*8 +: 8] = data[i];
            REQ[i] = 1'b1;
          end
        end
        if (!CLR && !CLR_ACK && $urandom_range(15) == 0) CLR = 1'b1;
      end
    end
    checks++;
    if (REQ !== '0 || CLR !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain: req=%b clr=%b still pending, want 0000 0", REQ, CLR);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_clr_first;
    test_clr_in_strobe;
    test_wdata_change;
    test_reset_mid_write;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
